// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one byte-level UART transmitter between four message requesters.
//   One-cycle request pulses are latched into pending. Pending requesters are
//   granted in round-robin order. The granted requester's fixed ASCII message
//   is streamed from an internal ROM, one byte per tx_start / tx_busy handshake.
//
//   Optional build macro: UART_SCHED_CRLF_EN
//     When defined, every message is followed by 0x0D 0x0A.
//
//   Parameters
//     NUM_REQ      number of requesters (fixed at 4, the ROM has 4 entries)
//     GAP_CYCLES   idle cycles after a message's last byte, before the next arbitration
//     ACK_TIMEOUT  cycles to wait for tx_busy to rise before the byte counts as dropped
//
//   Ports
//     clk, rst_n  clock, synchronous active-low reset
//     req         per-requester request pulses
//     tx_busy     busy flag from uart_tx
//     tx_start    one-cycle send pulse to uart_tx
//     tx_data     byte to send; held until the byte completes and while idle
//     active      high from grant until the last byte is done
//     grant_id    requester currently granted, or the one granted last
//     done        one-cycle pulse when a message's last byte completes
//     pending     latched outstanding requests
//     drop_err    sticky flag, set on any acknowledge timeout
module uart_tx_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int GAP_CYCLES  = 0,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               tx_busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   output logic               active,
   output logic [1:0]         grant_id,
   output logic               done,
   output logic [NUM_REQ-1:0] pending,
   output logic               drop_err
);

   typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_HI, WAIT_LO, NEXT, GAP} state_t;

`ifdef UART_SCHED_CRLF_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 0;
`endif

   state_t               state, nstate;
   logic [1:0]           ptr;
   logic [2:0]           idx;
   logic [7:0]           to_cnt;
   logic [7:0]           gap_cnt;
   logic [1:0]           winner;
   logic [NUM_REQ-1:0]   clr;
   logic                 last;
   logic                 to_expire;
   logic                 gap_expire;

   function automatic logic [2:0] base_len(input logic [1:0] id);
      case (id)
         2'd0:    return 3'd4;
         2'd1:    return 3'd4;
         2'd2:    return 3'd3;
         default: return 3'd2;
      endcase
   endfunction

   function automatic logic [2:0] msg_len(input logic [1:0] id);
      return 3'(int'(base_len(id)) + EXTRA);
   endfunction

   function automatic logic [7:0] rom_byte(input logic [1:0] id, input logic [2:0] i);
      logic [7:0] b;
      b = 8'h00;
      case (id)
         2'd0: case (i)   // "POLO"
            3'd0: b = 8'h50;  3'd1: b = 8'h4F;  3'd2: b = 8'h4C;  3'd3: b = 8'h4F;
            default: b = 8'h00;
         endcase
         2'd1: case (i)   // "PING"
            3'd0: b = 8'h50;  3'd1: b = 8'h49;  3'd2: b = 8'h4E;  3'd3: b = 8'h47;
            default: b = 8'h00;
         endcase
         2'd2: case (i)   // "ERR"
            3'd0: b = 8'h45;  3'd1: b = 8'h52;  3'd2: b = 8'h52;
            default: b = 8'h00;
         endcase
         default: case (i) // "OK"
            3'd0: b = 8'h4F;  3'd1: b = 8'h4B;
            default: b = 8'h00;
         endcase
      endcase
`ifdef UART_SCHED_CRLF_EN
      if (i == base_len(id))              b = 8'h0D;
      else if (i == base_len(id) + 3'd1)  b = 8'h0A;
`endif
      return b;
   endfunction

   // Round-robin search starting one past the last winner.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      winner = ptr;
      found  = 1'b0;
      cand   = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + 2'(k);
         if (!found && pending[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      clr = '0;
      if (state == GRANT) clr[winner] = 1'b1;
   end

   assign last       = (idx == msg_len(grant_id) - 3'd1);
   assign to_expire  = (to_cnt == 8'(ACK_TIMEOUT - 1));
   assign gap_expire = (gap_cnt == 8'(GAP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate   = state;
      tx_start = 1'b0;
      done     = 1'b0;
      case (state)
         // req is included so a request sampled on this edge goes straight to GRANT,
         // which puts tx_start in the second cycle after the sampling edge.
         IDLE:    if ((pending | req) != '0) nstate = GRANT;
         GRANT:   nstate = START;
         START: begin
            tx_start = 1'b1;
            nstate   = WAIT_HI;
         end
         WAIT_HI: begin
            if (tx_busy)        nstate = WAIT_LO;
            else if (to_expire) nstate = NEXT;
         end
         WAIT_LO: if (!tx_busy) nstate = NEXT;
         NEXT: begin
            if (last) begin
               done   = 1'b1;
               nstate = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               nstate = START;
            end
         end
         GAP:     if (gap_expire) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr      <= 2'd3;
         idx      <= '0;
         to_cnt   <= '0;
         gap_cnt  <= '0;
         grant_id <= '0;
         active   <= 1'b0;
         pending  <= '0;
         drop_err <= 1'b0;
         tx_data  <= '0;
      end else begin
         // Set wins over the grant clear, so a requester can re-queue itself.
         pending <= (pending & ~clr) | req;
         case (state)
            GRANT: begin
               grant_id <= winner;
               ptr      <= winner;
               active   <= 1'b1;
               idx      <= '0;
               tx_data  <= rom_byte(winner, 3'd0);
            end
            START: to_cnt <= '0;
            WAIT_HI: begin
               if (!tx_busy) begin
                  if (to_expire) drop_err <= 1'b1;
                  else           to_cnt   <= to_cnt + 8'd1;
               end
            end
            NEXT: begin
               if (last) begin
                  active  <= 1'b0;
                  gap_cnt <= '0;
               end else begin
                  // The previous byte is finished or dropped, so tx_data may change now.
                  idx     <= idx + 3'd1;
                  tx_data <= rom_byte(grant_id, idx + 3'd1);
               end
            end
            GAP: gap_cnt <= gap_cnt + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single byte-level UART transmitter between four message requesters. It latches one-cycle request pulses and picks the next requester round-robin. It then streams that requester's fixed ASCII message from an internal ROM, one byte per transmitter send/busy handshake. It sits between the command detectors (buffer comparators, status logic) and uart_tx, and replaces the direct comparator-to-transmitter trigger.

Parameters:
NUM_REQ, 4, number of requesters; only 4 supported (ROM is fixed at 4 entries)
GAP_CYCLES, 0, idle clk cycles inserted after a message's last byte completes before the next arbitration (0..255)
ACK_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start before treating the byte as dropped (1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
req  input  4  per-requester one-cycle request pulses
tx_busy  input  1  busy from uart_tx
tx_start  output  1  one-cycle send pulse to uart_tx
tx_data  output  8  byte to transmit; stable from tx_start until byte completes
active  output  1  high while a message is being sent (grant through last byte done)
grant_id  output  2  requester currently or last granted
done  output  1  one-cycle pulse when a message's last byte completes
pending  output  4  latched outstanding requests
drop_err  output  1  sticky; set on any ACK_TIMEOUT expiry

Behaviour:
- Reset (synchronous, rst_n low at clk edge): all outputs 0, FSM to IDLE, round-robin pointer = 3 so the first search starts at requester 0, gap and timeout counters 0.
- A reset mid-message aborts immediately; the remaining bytes are discarded. Any byte already in uart_tx completes on its own.
- Request latch: req[i] high at an edge sets pending[i]. Clearing happens at grant. If set and clear hit the same bit on the same edge, set wins, so a requester can re-queue its own message during transmission.
- ROM:
  - id0 "POLO" = 50 4F 4C 4F
  - id1 "PING" = 50 49 4E 47
  - id2 "ERR" = 45 52 52
  - id3 "OK" = 4F 4B
  - Byte index is 3 bits. Per-id length is stored alongside the ROM.
- FSM states: IDLE, GRANT, START, WAIT_HI, WAIT_LO, NEXT, GAP.
- IDLE: if pending != 0, go to GRANT.
- GRANT: winner = first set bit searching pointer+1, pointer+2, ... modulo 4. Then:
  - grant_id <= winner, pointer <= winner, pending[winner] cleared, active <= 1, byte index <= 0.
  - Go to START.
- START: tx_start = 1 for exactly one cycle, tx_data = ROM[grant_id][idx]; go to WAIT_HI.
  - Latency: when idle, tx_start is high in the second cycle after the edge that sampled req.
- WAIT_HI: waits for tx_busy = 1, then goes to WAIT_LO.
  - If ACK_TIMEOUT cycles elapse first: set drop_err, go to NEXT; the byte is not retried.
  - tx_busy already high on entry counts as acknowledgement.
- WAIT_LO: waits for tx_busy = 0, then goes to NEXT. No timeout in this state.
- NEXT: if idx is the last byte:
  - pulse done, active <= 0.
  - Go to GAP if GAP_CYCLES > 0, else IDLE.
  - Otherwise idx += 1 and go to START.
- GAP: count GAP_CYCLES cycles, then go to IDLE. pending keeps latching during GAP.
- tx_start is never asserted while tx_busy is high, except when the previous byte's timeout was taken.
- tx_data holds its last value when idle.
- Requests arriving during a message never pre-empt it; they are served after it, in round-robin order.
- Simultaneous multiple requests: one grant per arbitration. The pointer advance guarantees no requester waits more than 3 other messages.

Optional Feature:
UART_SCHED_CRLF_EN:
- Defined: every message is followed by 0x0D 0x0A, sent as two extra bytes through the same START/WAIT handshake. Effective length = ROM length + 2. done pulses after the 0x0A byte completes.
- Undefined: messages are sent without terminator; the CRLF logic is absent.

Test Plan:
- Model tx_busy as rising 1 clk after tx_start and staying high 10 clks. Pulse req=0001 -> tx_data sequence 50,4F,4C,4F with one tx_start each; done pulses once; active falls; grant_id=0.
- After reset, pulse req=0101 in one cycle -> message id0 "POLO", then id2 "ERR". pending=0100 during the first message and 0000 after the second grant.
- Keep pending=1111 continuously refilled -> grant order 0,1,2,3,0,1; no id repeats before all others are served.
- Pulse req[3] during its own "OK" transmission -> "OK" is sent twice back-to-back (plus gap); pending[3]=1 after the first grant.
- Hold tx_busy=0 permanently, req=0010 -> after ACK_TIMEOUT=16 cycles per byte, drop_err=1. Four tx_start pulses spaced 18 cycles apart, then done.
- Assert rst_n=0 for 1 cycle during byte 2 of "PING" -> all outputs 0 next cycle; with UART_SCHED_CRLF_EN defined, a following req=0001 yields 50,4F,4C,4F,0D,0A.
